// File: rtl/div_if.sv
// Execute-stage <-> divider bus: level request in, registered {rem, quot} result out.
interface div_if #(parameter int WIDTH = 32);
   logic               signed_div_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               start_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle, signs fixed up at the end.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic  clk,
   input  logic  rst,
   div_if.slave  bus
);
   localparam int CW = $clog2(ITERS + 1);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t             r_state, w_state;
   logic [2*WIDTH:0]   r_work, w_work;
   logic [WIDTH-1:0]   r_divisor, w_divisor;
   logic [CW-1:0]      r_cnt, w_cnt;
   logic               r_neg_q, w_neg_q;
   logic               r_neg_r, w_neg_r;
   logic [2*WIDTH-1:0] r_result, w_result;
   logic               r_ready, w_ready;

   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH:0]   w_step;
   logic [WIDTH-1:0]   w_abs1, w_abs2, w_quot, w_rem;
   logic               w_sign1, w_sign2;

   assign bus.result_o = r_result;
   assign bus.ready_o  = r_ready;

   // Trial subtraction of the divisor from the current partial remainder
   assign w_diff = r_work[2*WIDTH:WIDTH] - {1'b0, r_divisor};
   assign w_step = w_diff[WIDTH] ? {r_work[2*WIDTH-1:0], 1'b0}
                                 : {w_diff[WIDTH-1:0], r_work[WIDTH-1:0], 1'b1};
   assign w_quot = r_neg_q ? -w_step[WIDTH-1:0]       : w_step[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -w_step[2*WIDTH:WIDTH+1] : w_step[2*WIDTH:WIDTH+1];

   // abs(most-negative) wraps to itself, which is the right magnitude read as unsigned
   assign w_sign1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
   assign w_sign2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
   assign w_abs1  = w_sign1 ? -bus.opdata1_i : bus.opdata1_i;
   assign w_abs2  = w_sign2 ? -bus.opdata2_i : bus.opdata2_i;

   always_comb begin
      w_state   = r_state;
      w_work    = r_work;
      w_divisor = r_divisor;
      w_cnt     = r_cnt;
      w_neg_q   = r_neg_q;
      w_neg_r   = r_neg_r;
      w_result  = r_result;
      w_ready   = r_ready;
      if (bus.annul_i) begin
         w_state  = FREE;
         w_ready  = 1'b0;
         w_result = '0;
      end else begin
         unique case (r_state)
            FREE: begin
               if (bus.start_i) begin
                  if (bus.opdata2_i == '0) begin
                     w_state = BYZERO;
                  end else begin
                     w_state   = ON;
                     w_divisor = w_abs2;
                     w_work    = {{WIDTH{1'b0}}, w_abs1, 1'b0};
                     w_neg_q   = w_sign1 ^ w_sign2;
                     w_neg_r   = w_sign1;
                     w_cnt     = '0;
                  end
               end
            end
            BYZERO: begin
               w_state  = END;
               w_result = '0;
               w_ready  = 1'b1;
            end
            ON: begin
               if (!bus.start_i) begin
                  w_state  = FREE;
                  w_ready  = 1'b0;
                  w_result = '0;
               end else begin
                  w_work = w_step;
                  w_cnt  = r_cnt + 1'b1;
                  if (r_cnt == CW'(ITERS - 1)) begin
                     w_state  = END;
                     w_result = {w_rem, w_quot};
                     w_ready  = 1'b1;
                  end
               end
            end
            END: begin
               if (!bus.start_i) begin
                  w_state  = FREE;
                  w_ready  = 1'b0;
                  w_result = '0;
               end
            end
            default: w_state = FREE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FREE;
         r_work    <= '0;
         r_divisor <= '0;
         r_cnt     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_result  <= '0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_work    <= w_work;
         r_divisor <= w_divisor;
         r_cnt     <= w_cnt;
         r_neg_q   <= w_neg_q;
         r_neg_r   <= w_neg_r;
         r_result  <= w_result;
         r_ready   <= w_ready;
      end
   end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider serving the execute stage for DIV/DIVU.
- Execute holds start_i high and stalls the pipeline until ready_o. It then writes result_o into HI/LO: remainder to HI, quotient to LO.
- Sole sequential arithmetic unit beside the execute stage. One division in flight at a time.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported.
- ITERS, 32, number of iteration cycles. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  32  dividend (rs)
- opdata2_i  input  32  divisor (rt)
- start_i  input  1  level request; held high by execute until ready_o is seen
- annul_i  input  1  flush (exception/eret); aborts any operation
- result_o  output  64  {remainder[31:0], quotient[31:0]}
- ready_o  output  1  result valid

Behaviour:
- Reset: rst is synchronous, active-high. On a clk edge with rst=1: state=FREE, ready_o=0, result_o=0, counter=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: FREE, BYZERO, ON, END.
- annul_i=1 at any edge (rst=0) has priority over all else: go to FREE, ready_o=0, result_o=0.
- FREE:
  - start_i=0: stay in FREE.
  - start_i=1 and opdata2_i==0: go to BYZERO.
  - Otherwise: go to ON and latch operands.
  - Signed latch: store abs(opdata1_i) and abs(opdata2_i), plus neg_q = sign1^sign2 and neg_r = sign1.
  - Unsigned latch: store operands raw, neg_q = neg_r = 0.
  - abs(0x80000000) = 0x80000000 treated as unsigned.
  - Initialise the 65-bit work register to {32'b0, dividend, 1'b0} and counter=0.
- BYZERO: next edge goes to END with result_o = 64'h0 and ready_o=1. Divide-by-zero result is defined as 0 for both fields.
- ON, each edge:
  - Compute diff = work[64:32] - {1'b0, divisor}.
  - If diff is negative: work = work << 1.
  - Else: work = {diff[31:0], work[31:0], 1'b1}.
  - counter += 1.
- ON exit on the edge where counter reaches ITERS:
  - quotient = work[31:0], remainder = work[64:33].
  - Apply signs: quotient negated if neg_q; remainder negated if neg_r (two's complement).
  - Register result_o = {remainder, quotient}, set ready_o=1, go to END.
- ON abort: start_i=0 at any ON edge goes to FREE, ready_o=0, result_o=0.
- Latency: from the FREE edge sampling start_i=1 to ready_o high is exactly 33 edges for a nonzero divisor and 2 edges for a zero divisor.
- END:
  - While start_i=1: hold ready_o=1 and result_o stable.
  - On an edge with start_i=0: go to FREE, ready_o=0, result_o=0.
  - A new request needs at least one cycle back in FREE.
- Operand changes after the FREE sampling edge are ignored.
- 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0. There is no trap.

Test Plan:
- Unsigned 100/7: DIVU, start held -> ready_o rises 33 edges after sampling; result_o = {32'd2, 32'd14}. Drop start -> next edge ready_o=0, result_o=0.
- Signed -7/2: DIV with 0xFFFFFFF9/0x00000002 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7/-2 -> q=0xFFFFFFFD, r=0x00000001.
- Divide by zero: opdata2_i=0, start_i=1 -> ready_o high after 2 edges, result_o=0. Same result in signed and unsigned mode.
- Corner values:
  - 0x80000000 / 0xFFFFFFFF signed -> q=0x80000000, r=0.
  - 0xFFFFFFFF / 1 unsigned -> q=0xFFFFFFFF, r=0.
  - 5/9 -> q=0, r=5.
- Abort: assert annul_i at iteration 10 -> FREE next edge, ready_o never rises. Repeat by dropping start_i mid-ON -> same. An immediate new request (100/7) then completes correctly in 33 edges.
- Reset mid-operation and back-to-back: rst=1 during ON -> all outputs 0 and state FREE at that edge. Two consecutive DIVs (ready, drop start one cycle, restart) -> both results correct, no stale data.
